// File: rtl/imm_extend_pipe.sv
// RV32/RV64 immediate generator: decodes the format, extends the immediate and
// queues {imm, fmt, tag, illegal} in a 2-entry valid/ready output buffer.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;
    localparam bit         IS_RV64  = (XLEN == 64);

    function automatic logic [2:0] decode_fmt(input logic [31:0] instr);
        logic [2:0] fmt;
        fmt = FMT_NONE;
        if (instr[1:0] != 2'b11) begin
            fmt = FMT_NONE;
        end else begin
            case (instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111: fmt = FMT_I;
                7'b0011011:                         fmt = IS_RV64 ? FMT_I : FMT_NONE;
                7'b0100011:                         fmt = FMT_S;
                7'b1100011:                         fmt = FMT_B;
                7'b0110111, 7'b0010111:             fmt = FMT_U;
                7'b1101111:                         fmt = FMT_J;
                7'b1110011:                         fmt = instr[14] ? FMT_Z : FMT_NONE;
                default:                            fmt = FMT_NONE;
            endcase
        end
        return fmt;
    endfunction

    // Sign bits are preloaded; each format then overwrites its low field.
    function automatic logic [XLEN-1:0] extend_imm(input logic [31:0] instr, input logic [2:0] fmt);
        logic [XLEN-1:0] imm;
        imm = {XLEN{instr[31]}};
        case (fmt)
            FMT_I: imm[11:0] = instr[31:20];
            FMT_S: imm[11:0] = {instr[31:25], instr[11:7]};
            FMT_B: imm[12:0] = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm[31:0] = {instr[31:12], 12'b0};
            FMT_J: imm[20:0] = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_Z: begin
                imm      = {XLEN{1'b0}};
                imm[4:0] = instr[19:15];
            end
            default: imm = {XLEN{1'b0}};
        endcase
        return imm;
    endfunction

    logic [2:0]       dec_fmt_s;
    logic [XLEN-1:0]  dec_imm_s;
    logic             dec_ill_s;
    logic             push_s;
    logic             pop_s;

    logic [XLEN-1:0]  imm_mem_r [2];
    logic [2:0]       fmt_mem_r [2];
    logic [TAG_W-1:0] tag_mem_r [2];
    logic             ill_mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;

    // Decode and extend ahead of the buffer write so stored entries are final
    always_comb begin
        dec_ill_s = (in_instr[1:0] != 2'b11);
        dec_fmt_s = decode_fmt(in_instr);
        dec_imm_s = extend_imm(in_instr, dec_fmt_s);
    end

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign push_s    = in_valid & in_ready;
    assign pop_s     = out_valid & out_ready;

    // Buffer storage, pointers and occupancy; flush empties without touching storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                imm_mem_r[i] <= {XLEN{1'b0}};
                fmt_mem_r[i] <= 3'd0;
                tag_mem_r[i] <= {TAG_W{1'b0}};
                ill_mem_r[i] <= 1'b0;
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else if (flush) begin
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                imm_mem_r[wr_ptr_r] <= dec_imm_s;
                fmt_mem_r[wr_ptr_r] <= dec_fmt_s;
                tag_mem_r[wr_ptr_r] <= in_tag;
                ill_mem_r[wr_ptr_r] <= dec_ill_s;
                wr_ptr_r            <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Present the head entry, zeroed while empty
    always_comb begin
        if (out_valid) begin
            out_imm     = imm_mem_r[rd_ptr_r];
            out_fmt     = fmt_mem_r[rd_ptr_r];
            out_tag     = tag_mem_r[rd_ptr_r];
            out_illegal = ill_mem_r[rd_ptr_r];
        end else begin
            out_imm     = {XLEN{1'b0}};
            out_fmt     = 3'd0;
            out_tag     = {TAG_W{1'b0}};
            out_illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: one XLEN=32 and one XLEN=64 instance
// sharing clock, reset and flush.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;

    logic        v32, rdy32, ov32, ordy32, ill32;
    logic [31:0] instr32, imm32;
    logic [4:0]  tag32, otag32;
    logic [2:0]  fmt32;

    logic        v64, rdy64, ov64, ordy64, ill64;
    logic [31:0] instr64;
    logic [63:0] imm64;
    logic [4:0]  tag64, otag64;
    logic [2:0]  fmt64;

    int n_checks = 0;
    int n_errors = 0;

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v32), .in_ready(rdy32), .in_instr(instr32), .in_tag(tag32),
        .out_valid(ov32), .out_ready(ordy32), .out_imm(imm32), .out_fmt(fmt32),
        .out_tag(otag32), .out_illegal(ill32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(v64), .in_ready(rdy64), .in_instr(instr64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(ordy64), .out_imm(imm64), .out_fmt(fmt64),
        .out_tag(otag64), .out_illegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Push one instruction with out_ready=1 and check it on the next cycle.
    task automatic push_chk(input bit wide, input logic [31:0] instr, input logic [4:0] tag,
                            input logic [63:0] exp_imm, input logic [2:0] exp_fmt,
                            input logic exp_ill, input string name);
        @(negedge clk);
        if (wide) begin
            check({name, ".rdy"}, {63'd0, rdy64}, 64'd1);
            v64 = 1'b1; instr64 = instr; tag64 = tag;
        end else begin
            check({name, ".rdy"}, {63'd0, rdy32}, 64'd1);
            v32 = 1'b1; instr32 = instr; tag32 = tag;
        end
        @(posedge clk); #1;
        v32 = 1'b0;
        v64 = 1'b0;
        if (wide) begin
            check({name, ".valid"}, {63'd0, ov64}, 64'd1);
            check({name, ".imm"}, imm64, exp_imm);
            check({name, ".fmt"}, {61'd0, fmt64}, {61'd0, exp_fmt});
            check({name, ".tag"}, {59'd0, otag64}, {59'd0, tag});
            check({name, ".ill"}, {63'd0, ill64}, {63'd0, exp_ill});
        end else begin
            check({name, ".valid"}, {63'd0, ov32}, 64'd1);
            check({name, ".imm"}, {32'd0, imm32}, exp_imm);
            check({name, ".fmt"}, {61'd0, fmt32}, {61'd0, exp_fmt});
            check({name, ".tag"}, {59'd0, otag32}, {59'd0, tag});
            check({name, ".ill"}, {63'd0, ill32}, {63'd0, exp_ill});
        end
    endtask

    task automatic step(input string name, input logic [4:0] exp_tag, input logic exp_v, input logic exp_rdy);
        @(posedge clk); #1;
        check({name, ".valid"}, {63'd0, ov32}, {63'd0, exp_v});
        check({name, ".rdy"}, {63'd0, rdy32}, {63'd0, exp_rdy});
        check({name, ".tag"}, {59'd0, otag32}, {59'd0, exp_tag});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        v32 = 1'b1; instr32 = 32'hFFF00093; tag32 = 5'd3; ordy32 = 1'b1;
        v64 = 1'b1; instr64 = 32'hFFF00093; tag64 = 5'd3; ordy64 = 1'b1;

        // 1: reset with in_valid held high
        repeat (3) @(posedge clk);
        #1;
        check("rst.rdy",   {63'd0, rdy32}, 64'd1);
        check("rst.valid", {63'd0, ov32},  64'd0);
        check("rst.imm",   {32'd0, imm32}, 64'd0);
        check("rst.fmt",   {61'd0, fmt32}, 64'd0);
        check("rst.tag",   {59'd0, otag32}, 64'd0);
        check("rst.ill",   {63'd0, ill32}, 64'd0);
        check("rst.valid64", {63'd0, ov64}, 64'd0);
        @(negedge clk);
        v32 = 1'b0; v64 = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst.nopush", {63'd0, ov32}, 64'd0);

        // 2: XLEN=32 formats, back-to-back
        push_chk(1'b0, 32'hFFF00093, 5'd1, 64'h00000000FFFFFFFF, 3'd1, 1'b0, "i32");
        push_chk(1'b0, 32'hFE112E23, 5'd2, 64'h00000000FFFFFFFC, 3'd2, 1'b0, "s32");
        push_chk(1'b0, 32'hFE000FE3, 5'd3, 64'h00000000FFFFFFFE, 3'd3, 1'b0, "b32");
        push_chk(1'b0, 32'h001000EF, 5'd4, 64'h0000000000000800, 3'd5, 1'b0, "j32");
        push_chk(1'b0, 32'h300FD073, 5'd5, 64'h000000000000001F, 3'd6, 1'b0, "z32");

        // 3: XLEN-dependent cases and illegal encoding
        push_chk(1'b1, 32'h800002B7, 5'd6, 64'hFFFFFFFF80000000, 3'd4, 1'b0, "u64");
        push_chk(1'b1, 32'h0000001B, 5'd7, 64'h0000000000000000, 3'd1, 1'b0, "iw64");
        push_chk(1'b0, 32'h0000001B, 5'd7, 64'h0000000000000000, 3'd0, 1'b0, "iw32");
        push_chk(1'b1, 32'h00000000, 5'd8, 64'h0000000000000000, 3'd0, 1'b1, "ill64");
        push_chk(1'b0, 32'h00000000, 5'd8, 64'h0000000000000000, 3'd0, 1'b1, "ill32");
        @(posedge clk); #1;
        check("drain.valid", {63'd0, ov32}, 64'd0);

        // 4: backpressure, hold and ordered drain
        @(negedge clk);
        ordy32 = 1'b0; v32 = 1'b1; instr32 = 32'hFFF00093; tag32 = 5'd1;
        step("bp.1", 5'd1, 1'b1, 1'b1);
        @(negedge clk); tag32 = 5'd2;
        step("bp.full", 5'd1, 1'b1, 1'b0);
        @(negedge clk); tag32 = 5'd3;
        step("bp.hold", 5'd1, 1'b1, 1'b0);
        check("bp.hold.imm", {32'd0, imm32}, 64'h00000000FFFFFFFF);
        @(negedge clk); ordy32 = 1'b1;
        step("bp.pop1", 5'd2, 1'b1, 1'b1);
        step("bp.pop2", 5'd3, 1'b1, 1'b1);
        @(negedge clk); v32 = 1'b0;
        step("bp.empty", 5'd0, 1'b0, 1'b1);

        // 5: flush with two buffered entries and a concurrent push
        @(negedge clk);
        ordy32 = 1'b0; v32 = 1'b1; tag32 = 5'd4;
        @(posedge clk);
        @(negedge clk); tag32 = 5'd5;
        step("fl.full", 5'd4, 1'b1, 1'b0);
        @(negedge clk); flush = 1'b1; tag32 = 5'd7;
        step("fl.flushed", 5'd0, 1'b0, 1'b1);
        @(negedge clk); flush = 1'b0; v32 = 1'b0;
        step("fl.nopush", 5'd0, 1'b0, 1'b1);
        @(negedge clk); v32 = 1'b1; tag32 = 5'd8;
        step("fl.resume", 5'd8, 1'b1, 1'b1);
        @(negedge clk); flush = 1'b1; tag32 = 5'd9;
        step("fl.dropin", 5'd0, 1'b0, 1'b1);
        @(negedge clk); flush = 1'b0; v32 = 1'b0;
        step("fl.dropin2", 5'd0, 1'b0, 1'b1);

        // 6: asynchronous reset with a full buffer
        @(negedge clk); v32 = 1'b1; tag32 = 5'd10;
        @(posedge clk);
        @(negedge clk); tag32 = 5'd11;
        step("ar.full", 5'd10, 1'b1, 1'b0);
        @(negedge clk); v32 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("ar.valid", {63'd0, ov32}, 64'd0);
        check("ar.rdy",   {63'd0, rdy32}, 64'd1);
        check("ar.tag",   {59'd0, otag32}, 64'd0);
        check("ar.imm",   {32'd0, imm32}, 64'd0);
        #1 rst_n = 1'b1;
        ordy32 = 1'b1;
        push_chk(1'b0, 32'hFE000FE3, 5'd12, 64'h00000000FFFFFFFE, 3'd3, 1'b0, "ar.after");
        @(posedge clk); #1;
        check("ar.drain", {63'd0, ov32}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
